// File: rtl/hamming_link_ctrl.sv
// Two-requester round-robin link controller over a Hamming(11,7) SEC channel.
// Optional HAM_STATS_EN enables saturating corrected/uncorrectable counters.
module hamming_link_ctrl #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [6:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [6:0]       req1_data,
  output logic             req1_ready,
  output logic [10:0]      ch_tx,
  input  logic [10:0]      ch_rx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_data,
  output logic             out_src,
  output logic             out_corrected,
  output logic             out_uncorr,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr
);

  typedef enum logic [1:0] {IDLE, SEND, CHECK, DELIVER} state_t;

  state_t      state, state_nx;
  logic        last_grant;
  logic        grant;
  logic        accept;
  logic        src_q;
  logic [3:0]  timer;
  logic [10:0] rx_q;
  logic [3:0]  syn;
  logic [10:0] fixed;
  logic        corr, unc;

  function automatic logic [10:0] enc(input logic [6:0] d);
    logic [10:0] c;
    c     = '0;
    c[2]  = d[0];
    c[4]  = d[1];
    c[5]  = d[2];
    c[6]  = d[3];
    c[8]  = d[4];
    c[9]  = d[5];
    c[10] = d[6];
    c[0]  = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
    c[1]  = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
    c[3]  = c[4] ^ c[5] ^ c[6];
    c[7]  = c[8] ^ c[9] ^ c[10];
    return c;
  endfunction

  function automatic logic [6:0] extract(input logic [10:0] c);
    return {c[10:8], c[6:4], c[2]};
  endfunction

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state == IDLE) && !grant && req0_valid;
  assign req1_ready = (state == IDLE) && grant && req1_valid;

  always_comb begin
    syn[0] = rx_q[0] ^ rx_q[2] ^ rx_q[4] ^ rx_q[6] ^ rx_q[8] ^ rx_q[10];
    syn[1] = rx_q[1] ^ rx_q[2] ^ rx_q[5] ^ rx_q[6] ^ rx_q[9] ^ rx_q[10];
    syn[2] = rx_q[3] ^ rx_q[4] ^ rx_q[5] ^ rx_q[6];
    syn[3] = rx_q[7] ^ rx_q[8] ^ rx_q[9] ^ rx_q[10];
    fixed  = rx_q;
    for (int unsigned i = 0; i < 11; i++) begin
      if (syn == 4'(i + 1)) fixed[i] = ~rx_q[i];
    end
    corr = (syn != 4'd0) && (syn <= 4'd11);
    unc  = (syn >= 4'd12);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SEND;
      SEND:    if (timer == 4'd0) state_nx = CHECK;
      CHECK:   state_nx = DELIVER;
      DELIVER: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      src_q         <= 1'b0;
      timer         <= '0;
      rx_q          <= '0;
      ch_tx         <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_src       <= 1'b0;
      out_corrected <= 1'b0;
      out_uncorr    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          last_grant <= grant;
          src_q      <= grant;
          ch_tx      <= enc(grant ? req1_data : req0_data);
          timer      <= 4'(SETTLE - 1);
        end
        SEND: begin
          if (timer == 4'd0) rx_q  <= ch_rx;
          else               timer <= timer - 4'd1;
        end
        CHECK: begin
          out_valid     <= 1'b1;
          out_data      <= extract(fixed);
          out_src       <= src_q;
          out_corrected <= corr;
          out_uncorr    <= unc;
        end
        DELIVER: if (out_ready) begin
          out_valid <= 1'b0;
          ch_tx     <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef HAM_STATS_EN
  logic [CNT_W-1:0] corr_q, unc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      corr_q <= '0;
      unc_q  <= '0;
    end else if (state == CHECK) begin
      if (corr && (corr_q != '1)) corr_q <= corr_q + CNT_W'(1);
      if (unc  && (unc_q  != '1)) unc_q  <= unc_q  + CNT_W'(1);
    end
  end

  assign cnt_corr   = corr_q;
  assign cnt_uncorr = unc_q;
`else
  assign cnt_corr   = '0;
  assign cnt_uncorr = '0;
`endif

endmodule

// File: tb/tb_hamming_link_ctrl.sv
// Scoreboard bench for hamming_link_ctrl: directed cases plus randomized traffic
// checked against a position-based Hamming reference model.
module tb_hamming_link_ctrl;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [6:0]       req0_data, req1_data;
  logic [10:0]      ch_tx, ch_rx;
  logic             out_valid, out_ready, out_src, out_corrected, out_uncorr;
  logic [6:0]       out_data;
  logic [CNT_W-1:0] cnt_corr, cnt_uncorr;
  logic [10:0]      cur_err;

  hamming_link_ctrl #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .ch_tx(ch_tx), .ch_rx(ch_rx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .out_corrected(out_corrected), .out_uncorr(out_uncorr),
    .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
  );

  // The channel flips the bits chosen for the word in flight.
  assign ch_rx = ch_tx ^ cur_err;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0]  data;
    bit          src;
    bit          corr;
    bit          unc;
    int unsigned vcyc;
    int unsigned ncorr;
    int unsigned nunc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned dpos[7] = '{3, 5, 6, 7, 9, 10, 11};

  bit          m_idle = 1'b1;
  bit          m_last = 1'b1;
  int unsigned m_vcyc = 0;
  int unsigned m_acc = 0;
  int unsigned m_ncorr = 0;
  int unsigned m_nunc = 0;
  logic [6:0]  m_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [10:0] ref_enc(input logic [6:0] d);
    logic [10:0] c;
    bit          x;
    c = '0;
    for (int unsigned k = 0; k < 7; k++) c[dpos[k]-1] = d[k];
    for (int unsigned p = 1; p <= 8; p = p * 2) begin
      x = 1'b0;
      for (int unsigned pos = 1; pos <= 11; pos++)
        if (pos != p && (pos & p) != 0) x ^= c[pos-1];
      c[p-1] = x;
    end
    return c;
  endfunction

  function automatic logic [6:0] ref_extract(input logic [10:0] c);
    logic [6:0] d;
    for (int unsigned k = 0; k < 7; k++) d[k] = c[dpos[k]-1];
    return d;
  endfunction

  // Syndrome = XOR of the 1-based positions of all set bits.
  function automatic int unsigned ref_syn(input logic [10:0] c);
    int unsigned s = 0;
    for (int unsigned pos = 1; pos <= 11; pos++) if (c[pos-1]) s ^= pos;
    return s;
  endfunction

  function automatic logic [10:0] rand_err();
    int unsigned kind = $urandom_range(0, 3);
    logic [10:0] e = '0;
    if (kind == 1) e[$urandom_range(0, 10)] = 1'b1;
    else if (kind >= 2) begin
      e[$urandom_range(0, 10)] = 1'b1;
      e[$urandom_range(0, 10)] = 1'b1;
    end
    return e;
  endfunction

  task automatic step(input bit v0, input bit v1, input logic [6:0] a, input logic [6:0] b,
                      input bit ordy, input logic [10:0] e);
    bit          g;
    exp_t        r;
    logic [10:0] rx;
    int unsigned s;
    @(negedge clk);
    req0_valid = v0; req1_valid = v1; req0_data = a; req1_data = b; out_ready = ordy;
    #1;
    g = (v0 && v1) ? !m_last : v1;
    chk("req0_ready", req0_ready, m_idle && v0 && !g);
    chk("req1_ready", req1_ready, m_idle && v1 && g);
    if (m_idle) chk("ch_tx_idle", ch_tx, 0);
    if (!m_idle && cyc > m_acc && cyc <= m_acc + SETTLE) chk("ch_tx_send", ch_tx, ref_enc(m_word));
    if (m_idle && (v0 || v1)) begin
      m_last  = g;
      m_word  = g ? b : a;
      cur_err = e;
      rx      = ref_enc(m_word) ^ e;
      s       = ref_syn(rx);
      r.corr  = (s >= 1 && s <= 11);
      r.unc   = (s >= 12);
      if (r.corr) rx[s-1] = ~rx[s-1];
      r.data  = ref_extract(rx);
      r.src   = g;
      if (r.corr && m_ncorr < 65535) m_ncorr++;
      if (r.unc && m_nunc < 65535) m_nunc++;
      r.ncorr = m_ncorr;
      r.nunc  = m_nunc;
      r.vcyc  = cyc + SETTLE + 2;
      sbq.push_back(r);
      m_idle = 1'b0;
      m_acc  = cyc;
      m_vcyc = r.vcyc;
    end else if (!m_idle && cyc >= m_vcyc && ordy) begin
      m_idle = 1'b1;
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
    m_idle = 1'b1; m_last = 1'b1; m_ncorr = 0; m_nunc = 0; cur_err = '0;
    sbq.delete();
    @(negedge clk);
    #1;
    chk("rst_ch_tx", ch_tx, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cnt_corr", cnt_corr, 0);
    chk("rst_cnt_uncorr", cnt_uncorr, 0);
    rst = 1'b0;
  endtask

  task automatic idle_steps(input int unsigned n, input bit ordy);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, ordy, '0);
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  initial begin
    bit prev_ov = 1'b0;
    exp_t f;
    forever begin
      @(negedge clk);
      #2;
      if (rst) prev_ov = 1'b0;
      else begin
        if (out_valid) begin
          if (sbq.size() == 0) chk("out_valid_unexpected", 1, 0);
          else begin
            f = sbq[0];
            if (!prev_ov) chk("valid_latency", cyc, f.vcyc);
            chk("out_data", out_data, f.data);
            chk("out_src", out_src, f.src);
            chk("out_corrected", out_corrected, f.corr);
            chk("out_uncorr", out_uncorr, f.unc);
`ifdef HAM_STATS_EN
            chk("cnt_corr", cnt_corr, f.ncorr);
            chk("cnt_uncorr", cnt_uncorr, f.nunc);
`else
            chk("cnt_corr", cnt_corr, 0);
            chk("cnt_uncorr", cnt_uncorr, 0);
`endif
            if (out_ready) void'(sbq.pop_front());
          end
        end else if (sbq.size() > 0 && cyc > sbq[0].vcyc) begin
          chk("out_valid_missing", 0, 1);
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    out_ready = 1'b0; cur_err = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("init_ch_tx", ch_tx, 0);
    chk("init_out_valid", out_valid, 0);
    chk("init_out_data", out_data, 0);
    chk("init_flags", {out_src, out_corrected, out_uncorr}, 0);
    chk("init_cnts", {cnt_corr, cnt_uncorr}, 0);
    rst = 1'b0;

    // Clean, single-error (syndrome 6) and bits-10/3 (syndrome 15) transfers of 7'h55.
    step(1'b1, 1'b0, 7'h55, '0, 1'b1, 11'h000);
    step(1'b0, 1'b0, '0, '0, 1'b1, '0);
    chk("ch_tx_h52f_a", ch_tx, 11'h52F);
    idle_steps(5, 1'b1);
    step(1'b1, 1'b0, 7'h55, '0, 1'b1, 11'h020);
    step(1'b0, 1'b0, '0, '0, 1'b1, '0);
    chk("ch_tx_h52f_b", ch_tx, 11'h52F);
    idle_steps(5, 1'b1);
    step(1'b1, 1'b0, 7'h55, '0, 1'b1, 11'h408);
    idle_steps(6, 1'b1);

    // Downstream stall while both requesters keep asking.
    step(1'b1, 1'b1, 7'h12, 7'h6C, 1'b0, 11'h004);
    for (int unsigned i = 0; i < SETTLE + 7; i++) step(1'b1, 1'b1, 7'h12, 7'h6C, 1'b0, '0);
    for (int unsigned i = 0; i < 6; i++) step(1'b1, 1'b1, 7'h33, 7'h44, 1'b1, '0);
    idle_steps(6, 1'b1);

    // Reset during SEND, then contention must start with req0 and alternate.
    step(1'b0, 1'b1, '0, 7'h7F, 1'b1, 11'h001);
    step(1'b0, 1'b0, '0, '0, 1'b1, '0);
    pulse_rst();
    for (int unsigned i = 0; i < 4 * (SETTLE + 3); i++)
      step(1'b1, 1'b1, 7'($urandom), 7'($urandom), 1'b1, rand_err());
    idle_steps(6, 1'b1);

    for (int unsigned i = 0; i < 600; i++)
      step(1'($urandom), 1'($urandom), 7'($urandom), 7'($urandom),
           ($urandom_range(0, 3) != 0), rand_err());

    idle_steps(20, 1'b1);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
